// File: rtl/core_pkg.sv
// Shared RV32I core definitions: reset defaults, fetch FSM encoding and the
// base opcode map that decode and immediate generation key on.
package core_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over a same-cycle push or pop.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [63:0]            wdata,
  output logic [63:0]            rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one imem read in flight and feeds
// decode from a small FIFO; redirects flush the FIFO and drop stale data.
//
// state      | meaning
// FETCH_IDLE | no request; waiting for a free FIFO slot
// FETCH_REQ  | imem_req_o high at fetch_pc, holding until granted
// FETCH_WAIT | request granted, waiting for rvalid (dropped if discard set)
module instruction_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e  state, state_d;
  logic [31:0]   fetch_pc, fetch_pc_d;
  logic          discard, discard_d;
  logic          push, pop;
  logic [63:0]   head;
  logic [CW-1:0] count, count_after;
  logic          full, empty;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata ({fetch_pc, imem_rdata_i}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign push = (state == FETCH_WAIT) && imem_rvalid_i && !discard && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i;
  // Occupancy after this edge; a new request needs a slot guaranteed for its response.
  assign count_after = redirect_i ? '0 : count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_VECTOR;
      discard  <= 1'b0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      discard  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state;
    discard_d  = discard;
    fetch_pc_d = fetch_pc;
    case (state)
      FETCH_IDLE: begin
        if (redirect_i || !full) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_gnt_i) begin
          state_d   = FETCH_WAIT;
          discard_d = redirect_i;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = (count_after < DEPTH_C) ? FETCH_REQ : FETCH_IDLE;
        end else if (redirect_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (redirect_i)  fetch_pc_d = word_align(redirect_pc_i);
    else if (push)   fetch_pc_d = fetch_pc + 32'd4;
  end

  assign imem_req_o    = (state == FETCH_REQ);
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = !empty && !redirect_i;
  assign instr_o       = empty ? NOP_INSTR : head[31:0];
  assign pc_o          = empty ? 32'h0 : head[63:32];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RV32I core.
- Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PC in a small FIFO and presents them to decode with a valid/ready handshake. Decode slices the word into fields and feeds the immediate generator.
- Handles control-flow redirects (branch, JAL, JALR) by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, entries of {pc, instr}; power of two, at least 2.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_o  output  1  read request to instruction memory.
- imem_addr_o  output  32  word-aligned read address; bits [1:0] are always 0.
- imem_gnt_i  input  1  memory accepted the request this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  read data (instruction word).
- redirect_i  input  1  control-flow change from execute.
- redirect_pc_i  input  32  target PC; bits [1:0] are ignored and forced to 0.
- instr_valid_o  output  1  instr_o/pc_o hold a valid entry.
- instr_ready_i  input  1  decode accepts the entry.
- instr_o  output  32  instruction word to decode.
- pc_o  output  32  PC of instr_o.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_VECTOR; state IDLE; FIFO empty; discard flag 0.
  - imem_req_o=0, imem_addr_o=RESET_VECTOR, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0.
- FSM states IDLE, REQ, WAIT. At most one request outstanding.
- IDLE -> REQ when fifo_count + 0 < FIFO_DEPTH. The first request is issued in the first cycle after rst_n deasserts.
- REQ:
  - imem_req_o=1, imem_addr_o=fetch_pc. Address is held stable until grant.
  - On imem_gnt_i: go to WAIT.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i, if discard=0: push {fetch_pc, imem_rdata_i}, then fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If discard=1: drop the data and clear discard.
  - Next state is REQ if FIFO space remains after the push (counting a same-cycle pop), else IDLE.
- Credit rule: a request is issued only if the FIFO is guaranteed a free slot for its response, so the FIFO never overflows.
- Throughput: with gnt in the request cycle and rvalid one cycle later, one instruction per 2 cycles. instr_valid_o rises the cycle after rvalid (registered FIFO).
- Output:
  - instr_valid_o = !fifo_empty && !redirect_i. The redirect mask is combinational.
  - A pop occurs on instr_valid_o && instr_ready_i.
  - instr_o/pc_o show the FIFO head; NOP/0 when empty.
- Redirect (redirect_i=1), taking effect at the next edge:
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}; FIFO flushed. A flush beats a same-cycle push or pop.
  - In REQ without grant: next cycle imem_req_o stays 1 with the new address. Withdrawal/retarget is permitted by the imem protocol.
  - REQ with imem_gnt_i in the same cycle, or WAIT without rvalid: set discard=1 and go to WAIT. The response is dropped, then a new REQ is issued.
  - WAIT with rvalid in the same cycle: drop the data and go to REQ.
  - IDLE: go to REQ.
  - Back-to-back redirects: the last one wins; discard never exceeds one pending response.
- Redirect during reset has no effect. Reset mid-transaction returns everything to reset values. A stale rvalid arriving after reset is ignored in IDLE/REQ.
- imem_rvalid_i outside WAIT is ignored.

Decomposition:
- Shared package core_pkg: NOP_INSTR = 32'h0000_0013, default RESET_VECTOR, fetch FSM state encoding, and the opcode constants already used by decode/immediate generation.
- Sub-module fetch_fifo: synchronous FIFO, parameter DEPTH, 64-bit data, push/pop/flush, count/full/empty outputs. Flush has priority over push/pop.

Test Plan:
- Reset release, 0-wait memory returning 0x00500093 at 0x0 and 0x00A00113 at 0x4, ready=1 → imem_addr_o 0x0 then 0x4; outputs (pc 0x0, 0x00500093) then (pc 0x4, 0x00A00113); one instruction per 2 cycles.
- instr_ready_i=0 for 10 cycles → exactly FIFO_DEPTH=2 entries fetched (0x0, 0x4), imem_req_o low afterwards; after ready=1, entries drain in order and fetching resumes at 0x8.
- Redirect to 0x0000_0103 while a response is outstanding (rvalid 3 cycles later) → stale data is dropped and never appears; next imem_addr_o is 0x0000_0100; first output is pc 0x100.
- Redirect in the same cycle as imem_rvalid_i and a pending pop → data is dropped, FIFO is empty next cycle, instr_valid_o=0 in the redirect cycle, next request goes to the target.
- Redirect to 0xFFFF_FFFC, then one fetch → pc_o 0xFFFF_FFFC, next imem_addr_o 0x0000_0000.
- rst_n asserted asynchronously mid-WAIT → all outputs at reset values immediately; a late rvalid is ignored; after release the first request is at RESET_VECTOR.
